// File: rtl/reg_serial_rd.sv
// Parallel-in, serial-out register reader: captures a WIDTH-bit word on load and
// streams it LSB-first over a valid/ready handshake, then pulses done.
module reg_serial_rd #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             last,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Without a handshake everything holds, so sout stays stable under backpressure.
        if (sout_ready) begin
          shreg_d = shreg_q >> 1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registered state only, so they settle to reset values at the reset edge.
  assign busy       = (state_q == SHIFT) || (state_q == DONE);
  assign sout_valid = (state_q == SHIFT);
  assign sout       = shreg_q[0];
  assign last       = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign done       = (state_q == DONE);

endmodule
